// File: rtl/sdram_pkg.sv
// Shared constants and types for the SDRAM control stage.
// Call-bit positions match the sdram_funcmod iCall vector.
package sdram_pkg;

  localparam int FC_WR   = 3;
  localparam int FC_RD   = 2;
  localparam int FC_REF  = 1;
  localparam int FC_INIT = 0;

  localparam int UC_WR = 1;
  localparam int UC_RD = 0;

  localparam logic [13:0] TREF_DEFAULT = 14'd1040;

  typedef enum logic [2:0] {
    INIT_CALL,
    IDLE,
    REF,
    WR,
    RD,
    GAP
  } stateT;

  function automatic logic [3:0] fcBit(input int unsigned idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/sdram_reftimer.sv
// Auto-refresh interval timer: raises a pending flag every TREF clocks and
// latches a sticky overrun when an interval expires with a refresh still owed.
module sdram_reftimer
  import sdram_pkg::*;
#(
  parameter logic [13:0] TREF = TREF_DEFAULT
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic iEnable,
  input  logic iClear,
  output logic oPending,
  output logic oOvr
);

  logic [13:0] count;
  logic        wrap;

  assign wrap = iEnable && (count == TREF - 14'd1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count    <= '0;
      oPending <= 1'b0;
      oOvr     <= 1'b0;
    end else begin
      if (iEnable) count <= wrap ? 14'd0 : count + 14'd1;
      // A new interval expiring on the clear edge re-arms the request.
      if (wrap) oPending <= 1'b1;
      else if (iClear) oPending <= 1'b0;
      if (wrap && oPending && !iClear) oOvr <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_ctrlmod.sv
// SDRAM control stage: power-up init, refresh scheduling, user write/read
// arbitration and the one-hot call/done handshake towards sdram_funcmod.
module sdram_ctrlmod
  import sdram_pkg::*;
#(
  parameter logic [13:0] TREF = TREF_DEFAULT,
  parameter int          AW   = 24,
  parameter int          DW   = 64
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [1:0]    iCall,
  output logic [1:0]    oDone,
  input  logic [AW-1:0] iAddr,
  input  logic [DW-1:0] iData,
  output logic [DW-1:0] oData,
  output logic          oReady,
  output logic          oRefOvr,
  output logic [3:0]    oFCall,
  input  logic          iFDone,
  output logic [AW-1:0] oFAddr,
  output logic [DW-1:0] oFData,
  input  logic [DW-1:0] iFData
);

  stateT state;
  logic  refPending;
  logic  refClear;

  assign refClear = (state == IDLE) && refPending;

  sdram_reftimer #(.TREF(TREF)) uRefTimer (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .iEnable  (oReady),
    .iClear   (refClear),
    .oPending (refPending),
    .oOvr     (oRefOvr)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state  <= INIT_CALL;
      oFCall <= '0;
      oDone  <= '0;
      oReady <= 1'b0;
      oData  <= '0;
      oFAddr <= '0;
      oFData <= '0;
    end else begin
      oDone <= '0;
      case (state)
        INIT_CALL: begin
          if (oFCall[FC_INIT] && iFDone) begin
            oFCall <= '0;
            oReady <= 1'b1;
            state  <= GAP;
          end else begin
            oFCall <= fcBit(FC_INIT);
          end
        end
        IDLE: begin
          // Refresh outranks user traffic; write outranks read.
          if (refPending) begin
            oFCall <= fcBit(FC_REF);
            state  <= REF;
          end else if (iCall[UC_WR]) begin
            oFCall <= fcBit(FC_WR);
            oFAddr <= iAddr;
            oFData <= iData;
            state  <= WR;
          end else if (iCall[UC_RD]) begin
            oFCall <= fcBit(FC_RD);
            oFAddr <= iAddr;
            state  <= RD;
          end
        end
        REF: begin
          if (iFDone) begin
            oFCall <= '0;
            state  <= GAP;
          end
        end
        WR: begin
          if (iFDone) begin
            oFCall       <= '0;
            oDone[UC_WR] <= 1'b1;
            state        <= GAP;
          end
        end
        RD: begin
          if (iFDone) begin
            oFCall       <= '0;
            oData        <= iFData;
            oDone[UC_RD] <= 1'b1;
            state        <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= INIT_CALL;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_ctrlmod.sv
// Scoreboard bench for sdram_ctrlmod with a behavioural funcmod and an
// independent refresh-interval model.
module tb_sdram_ctrlmod;
  import sdram_pkg::*;

  localparam int AW       = 24;
  localparam int DW       = 64;
  localparam int OP_DUR   = 4;
  localparam int INIT_DUR = 20;
  localparam int TREF_TB  = 16;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic [1:0]    iCall = '0;
  logic [1:0]    oDone;
  logic [AW-1:0] iAddr = '0;
  logic [DW-1:0] iData = '0;
  logic [DW-1:0] oData;
  logic          oReady;
  logic          oRefOvr;
  logic [3:0]    oFCall;
  logic          iFDone = 1'b0;
  logic [AW-1:0] oFAddr;
  logic [DW-1:0] oFData;
  logic [DW-1:0] iFData = '0;

  sdram_ctrlmod #(.TREF(14'(TREF_TB)), .AW(AW), .DW(DW)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .iCall   (iCall),
    .oDone   (oDone),
    .iAddr   (iAddr),
    .iData   (iData),
    .oData   (oData),
    .oReady  (oReady),
    .oRefOvr (oRefOvr),
    .oFCall  (oFCall),
    .iFDone  (iFDone),
    .oFAddr  (oFAddr),
    .oFData  (oFData),
    .iFData  (iFData)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]    done;
    logic [DW-1:0] data;
  } doneExpT;

  doneExpT       doneQ[$];
  logic [AW-1:0] wrAddrQ[$];
  logic [DW-1:0] wrDataQ[$];
  logic [AW-1:0] rdAddrQ[$];

  // Behavioural funcmod: one-cycle done pulse after the call has been high
  // for the operation duration; refresh can be stalled indefinitely.
  logic blockRef = 1'b0;
  int   fcnt     = 0;
  initial forever begin
    @(negedge CLOCK);
    if (RESET) begin
      iFDone = 1'b0;
      fcnt   = 0;
    end else if (iFDone) begin
      iFDone = 1'b0;
      fcnt   = 0;
    end else if (oFCall != 4'b0000 && !(blockRef && oFCall == 4'b0010)) begin
      fcnt++;
      if (fcnt >= ((oFCall == 4'b0001) ? INIT_DUR : OP_DUR)) begin
        iFDone = 1'b1;
        fcnt   = 0;
      end
    end else begin
      fcnt = 0;
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  logic [3:0] prevCall  = '0;
  logic [1:0] prevDone  = '0;
  logic       readyPrev = 1'b0;
  int         mCnt      = 0;
  logic       mPend     = 1'b0;
  logic       mOvr      = 1'b0;
  int         refCount  = 0;
  logic       clr;
  logic       wrap;
  doneExpT    e;

  initial forever begin
    @(posedge CLOCK);
    #1;
    if (RESET) begin
      mCnt  = 0;
      mPend = 1'b0;
      mOvr  = 1'b0;
    end else begin
      clr = 1'b0;
      if (prevCall == 4'b0000 && oFCall != 4'b0000) begin
        case (oFCall)
          4'b1000: begin
            check("wr_refresh_priority", mPend, 1'b0);
            check("wr_expected", wrAddrQ.size() != 0, 1'b1);
            if (wrAddrQ.size() != 0) begin
              check("wr_addr", oFAddr, wrAddrQ.pop_front());
              check("wr_data", oFData, wrDataQ.pop_front());
            end
          end
          4'b0100: begin
            check("rd_refresh_priority", mPend, 1'b0);
            check("rd_expected", rdAddrQ.size() != 0, 1'b1);
            if (rdAddrQ.size() != 0) check("rd_addr", oFAddr, rdAddrQ.pop_front());
          end
          4'b0010: begin
            check("ref_due", mPend, 1'b1);
            clr = 1'b1;
            refCount++;
          end
          4'b0001: ;
          default: check("fcall_onehot", $countones(oFCall), 1);
        endcase
      end
      if (iFDone && prevCall != 4'b0000) check("fcall_drop", oFCall, 4'b0000);
      if (prevDone != 2'b00) check("done_width", oDone, 2'b00);
      if (oDone != 2'b00) begin
        check("done_ready", oReady, 1'b1);
        check("done_expected", doneQ.size() != 0, 1'b1);
        if (doneQ.size() != 0) begin
          e = doneQ.pop_front();
          check("done_kind", oDone, e.done);
          if (e.done == 2'b01) check("rd_data", oData, e.data);
        end
      end
      wrap = 1'b0;
      if (readyPrev) begin
        if (mCnt == TREF_TB - 1) begin
          mCnt = 0;
          wrap = 1'b1;
        end else begin
          mCnt++;
        end
      end
      if (wrap) begin
        if (mPend && !clr) mOvr = 1'b1;
        mPend = 1'b1;
      end else if (clr) begin
        mPend = 1'b0;
      end
      check("ref_ovr", oRefOvr, mOvr);
    end
    prevCall  = oFCall;
    prevDone  = oDone;
    readyPrev = oReady;
  end

  task automatic waitDone(input int bitIdx, input string name);
    int n = 0;
    while (n < 200) begin
      @(posedge CLOCK);
      #1;
      if (oDone[bitIdx]) break;
      n++;
    end
    check({name, "_timeout"}, n < 200, 1'b1);
    @(negedge CLOCK);
  endtask

  task automatic waitReady();
    int n = 0;
    int callCycles = 0;
    forever begin
      @(posedge CLOCK);
      #1;
      if (oReady || n >= 500) break;
      n++;
      if (oFCall == 4'b0001) callCycles++;
      check("init_no_done", oDone, 2'b00);
    end
    check("init_ready", oReady, 1'b1);
    check("init_call_len", callCycles, INIT_DUR);
    check("init_call_drop", oFCall, 4'b0000);
    @(negedge CLOCK);
  endtask

  task automatic startWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wrAddrQ.push_back(a);
    wrDataQ.push_back(d);
    doneQ.push_back({2'b10, {DW{1'b0}}});
    iAddr     = a;
    iData     = d;
    iCall[1]  = 1'b1;
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    startWrite(a, d);
    waitDone(1, "wr");
    iCall[1] = 1'b0;
  endtask

  task automatic doRead(input logic [AW-1:0] a, input logic [DW-1:0] fd);
    rdAddrQ.push_back(a);
    doneQ.push_back({2'b01, fd});
    iFData   = fd;
    iAddr    = a;
    iCall[0] = 1'b1;
    waitDone(0, "rd");
    iCall[0] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    check("rst_fcall", oFCall, 4'b0000);
    check("rst_done", oDone, 2'b00);
    check("rst_ready", oReady, 1'b0);
    check("rst_ovr", oRefOvr, 1'b0);
    check("rst_fdata", {oFAddr, oFData, oData}, '0);

    // A write held during init must wait for init to finish.
    RESET = 1'b0;
    startWrite(24'h40_1234, 64'h1111_2222_3333_4444);
    waitReady();
    waitDone(1, "wr_first");
    iCall[1] = 1'b0;

    doRead(24'h12_3456, 64'hDEAD_BEEF_CAFE_F00D);
    doRead(24'hFF_FFFF, 64'h0123_4567_89AB_CDEF);
    doWrite(24'h00_0000, 64'hFFFF_FFFF_FFFF_FFFF);

    // Simultaneous write and read: write first, one GAP, then read.
    wrAddrQ.push_back(24'h2A_0001);
    wrDataQ.push_back(64'hA5A5_5A5A_0F0F_F0F0);
    doneQ.push_back({2'b10, {DW{1'b0}}});
    rdAddrQ.push_back(24'h15_0002);
    doneQ.push_back({2'b01, 64'h5555_AAAA_1234_8765});
    iFData = 64'h5555_AAAA_1234_8765;
    iAddr  = 24'h2A_0001;
    iData  = 64'hA5A5_5A5A_0F0F_F0F0;
    iCall  = 2'b11;
    waitDone(1, "both_wr");
    iCall[1] = 1'b0;
    iAddr    = 24'h15_0002;
    n = 0;
    do begin
      @(posedge CLOCK);
      #1;
      n++;
    end while (oFCall == 4'b0000 && n < 10);
    check("gap_cycles", n, 2);
    waitDone(0, "both_rd");
    iCall[0] = 1'b0;

    // Continuous writes: refreshes must interleave.
    r0 = refCount;
    for (int i = 0; i < 8; i++) doWrite(24'h10_0000 + 24'(i), 64'(i) * 64'h0101_0101_0101_0101);
    check("refresh_inserted", refCount >= r0 + 2, 1'b1);

    // Stall a refresh across two intervals.
    check("ovr_before", oRefOvr, 1'b0);
    blockRef = 1'b1;
    r0 = refCount;
    n = 0;
    while (refCount == r0 && n < 100) begin
      @(negedge CLOCK);
      n++;
    end
    check("ovr_ref_started", refCount != r0, 1'b1);
    repeat (40) @(negedge CLOCK);
    check("ovr_set", oRefOvr, 1'b1);
    blockRef = 1'b0;
    repeat (30) @(negedge CLOCK);
    check("ovr_sticky", oRefOvr, 1'b1);

    // Reset in the middle of a read.
    rdAddrQ.push_back(24'h33_0033);
    doneQ.push_back({2'b01, 64'h7777_8888_9999_AAAA});
    iFData   = 64'h7777_8888_9999_AAAA;
    iAddr    = 24'h33_0033;
    iCall[0] = 1'b1;
    n = 0;
    while (oFCall != 4'b0100 && n < 100) begin
      @(negedge CLOCK);
      n++;
    end
    check("midrd_started", oFCall, 4'b0100);
    @(negedge CLOCK);
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    check("midrd_fcall", oFCall, 4'b0000);
    check("midrd_done", oDone, 2'b00);
    check("midrd_ready", oReady, 1'b0);
    check("midrd_ovr", oRefOvr, 1'b0);
    doneQ.delete();
    rdAddrQ.delete();
    wrAddrQ.delete();
    wrDataQ.delete();
    iCall = 2'b00;
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    waitReady();
    doWrite(24'h0B_EEF0, 64'hFEED_FACE_0000_0001);
    doRead(24'h0B_EEF0, 64'hC0DE_C0DE_1357_2468);

    repeat (5) @(negedge CLOCK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
